reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 32 +++
 rtl/reg_write_arbiter.sv | 122 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared constants and one-hot/index helpers for the register write arbiter.
// Helpers work on the largest supported requester count (8); callers cast in and out.
package reg_arb_pkg;
   localparam int DefDataWidth = 32;
   localparam int DefNumReq    = 4;
   localparam int MaxReq       = 8;
   localparam int MaxIdxW      = 3;
   localparam int DefIdxW      = $clog2(DefNumReq);

   function automatic logic [MaxReq-1:0] idx2oh(input logic [MaxIdxW-1:0] idx);
      return MaxReq'(1) << idx;
   endfunction

   function automatic logic [MaxIdxW-1:0] oh2idx(input logic [MaxReq-1:0] oh);
      logic [MaxIdxW-1:0] idx;
      idx = '0;
      for (int i = 0; i < MaxReq; i++) begin
         if (oh[i]) idx = MaxIdxW'(i);
      end
      return idx;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first request at or above the pointer, wrapping.
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter int NumReq = DefNumReq,
   parameter int IdxW   = DefIdxW
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [NumReq-1:0] gnt_o,
   output logic [IdxW-1:0]   idx_o,
   output logic              any_o
);
   logic [NumReq-1:0] oh;
   int                pos;

   always_comb begin
      oh    = '0;
      any_o = 1'b0;
      pos   = 0;
      for (int k = 0; k < NumReq; k++) begin
         pos = (int'(ptr_i) + k) % NumReq;
         if (!any_o && req_i[pos]) begin
            any_o   = 1'b1;
            oh[pos] = 1'b1;
         end
      end
   end

   assign gnt_o = oh;
   assign idx_o = IdxW'(oh2idx(MaxReq'(oh)));
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbitrated writes into one shared register, one-cycle write latency.
// Optional lock-hold ownership is compiled in with REG_ARB_LOCK_EN.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter  int DataWidth = DefDataWidth,
   parameter  int NumReq    = DefNumReq,
   localparam int IdxW      = $clog2(NumReq)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        stall,
   input  logic [NumReq-1:0]           req,
   input  logic [NumReq*DataWidth-1:0] wdata,
   input  logic                        clr,
`ifdef REG_ARB_LOCK_EN
   input  logic [NumReq-1:0]           lock,
`endif
   output logic [NumReq-1:0]           gnt,
   output logic [IdxW-1:0]             gnt_id,
   output logic [DataWidth-1:0]        rdata,
   output logic                        rdy
);
   logic [DataWidth-1:0] rdata_q, rdata_d;
   logic                 rdy_q, rdy_d;
   logic [IdxW-1:0]      id_q, id_d;
   logic [IdxW-1:0]      ptr_q, ptr_d;
   logic [NumReq-1:0]    req_eff;
   logic [NumReq-1:0]    pick_oh;
   logic [IdxW-1:0]      pick_idx;
   logic                 pick_any;

   function automatic logic [IdxW-1:0] inc_ptr(input logic [IdxW-1:0] p);
      return (p == IdxW'(NumReq - 1)) ? '0 : p + 1'b1;
   endfunction

`ifdef REG_ARB_LOCK_EN
   logic            own_vld_q, own_vld_d;
   logic [IdxW-1:0] own_q, own_d;

   // While an owner holds the register, every other requester is masked off.
   assign req_eff = own_vld_q ? (req & NumReq'(idx2oh(MaxIdxW'(own_q)))) : req;
`else
   assign req_eff = req;
`endif

   rr_pick #(
      .NumReq(NumReq),
      .IdxW  (IdxW)
   ) u_pick (
      .req_i(req_eff),
      .ptr_i(ptr_q),
      .gnt_o(pick_oh),
      .idx_o(pick_idx),
      .any_o(pick_any)
   );

   assign gnt    = stall ? '0 : pick_oh;
   assign gnt_id = id_q;
   assign rdata  = rdata_q;
   assign rdy    = rdy_q;

   always_comb begin
      rdata_d = rdata_q;
      rdy_d   = rdy_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
`ifdef REG_ARB_LOCK_EN
      own_vld_d = own_vld_q;
      own_d     = own_q;
`endif
      if (!stall) begin
         if (pick_any) begin
            rdata_d = wdata[int'(pick_idx)*DataWidth +: DataWidth];
            rdy_d   = 1'b1;
            id_d    = pick_idx;
            ptr_d   = inc_ptr(pick_idx);
         end else if (clr) begin
            rdy_d = 1'b0;
         end
`ifdef REG_ARB_LOCK_EN
         if (own_vld_q) begin
            if (!lock[own_q] || !req[own_q]) begin
               own_vld_d = 1'b0;
               ptr_d     = inc_ptr(own_q);
            end else begin
               ptr_d = ptr_q;
            end
         end else if (pick_any && lock[pick_idx]) begin
            own_vld_d = 1'b1;
            own_d     = pick_idx;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
         rdy_q   <= 1'b0;
         id_q    <= '0;
         ptr_q   <= '0;
      end else begin
         rdata_q <= rdata_d;
         rdy_q   <= rdy_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef REG_ARB_LOCK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         own_vld_q <= 1'b0;
         own_q     <= '0;
      end else begin
         own_vld_q <= own_vld_d;
         own_q     <= own_d;
      end
   end
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: rule-level model compared every negedge,
// plus literal expectations. Lock scenario runs when REG_ARB_LOCK_EN is defined.
module tb_reg_write_arbiter;
   localparam int DW = 32;
   localparam int N  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall;
   logic [N-1:0]  req;
   logic [N*DW-1:0] wdata;
   logic          clr;
   logic [N-1:0]  lock;
   logic [N-1:0]  gnt;
   logic [1:0]    gnt_id;
   logic [DW-1:0] rdata;
   logic          rdy;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   reg_write_arbiter #(.DataWidth(DW), .NumReq(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .req   (req),
      .wdata (wdata),
      .clr   (clr),
`ifdef REG_ARB_LOCK_EN
      .lock  (lock),
`endif
      .gnt   (gnt),
      .gnt_id(gnt_id),
      .rdata (rdata),
      .rdy   (rdy)
   );

   always #5 clk = ~clk;

   // Model state: what the spec says the register, pointer and owner hold.
   logic [DW-1:0] m_rdata;
   bit            m_rdy;
   int            m_id, m_ptr, m_owner;

   function automatic int winner();
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (req[j] && (m_owner < 0 || m_owner == j)) return j;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_gnt();
      int w;
      w = winner();
      if (stall || w < 0) return '0;
      return N'(1) << w;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_rdata = '0; m_rdy = 0; m_id = 0; m_ptr = 0; m_owner = -1;
      end else if (!stall) begin
         int w, nptr;
         w = winner();
         nptr = m_ptr;
         if (w >= 0) begin
            m_rdata = wdata[w*DW +: DW]; m_rdy = 1; m_id = w; nptr = (w + 1) % N;
         end else if (clr) begin
            m_rdy = 0;
         end
`ifdef REG_ARB_LOCK_EN
         if (m_owner >= 0) begin
            if (!lock[m_owner] || !req[m_owner]) begin
               nptr = (m_owner + 1) % N; m_owner = -1;
            end else begin
               nptr = m_ptr;
            end
         end else if (w >= 0 && lock[w]) begin
            m_owner = w;
         end
`endif
         m_ptr = nptr;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_gnt", 64'(gnt), 64'(exp_gnt()));
         chk("model_rdata", 64'(rdata), 64'(m_rdata));
         chk("model_rdy", 64'(rdy), 64'(m_rdy));
         chk("model_gnt_id", 64'(gnt_id), 64'(m_id));
      end
   end

   task automatic edge_tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; stall = 0; req = '0; clr = 0; lock = '0;
      for (int i = 0; i < N; i++) wdata[i*DW +: DW] = DW'(32'h10 + i);
      edge_tick();
      edge_tick();
      chk("reset_rdata", 64'(rdata), 64'h0);
      chk("reset_rdy", 64'(rdy), 64'h0);
      chk("reset_gnt_id", 64'(gnt_id), 64'h0);
      chk_en = 1'b1;
      rst = 1'b1;

      // Four full-request edges walk requesters 0..3 in order.
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         edge_tick();
         chk("rr_rdata", 64'(rdata), 64'(32'h10 + i));
         chk("rr_gnt_id", 64'(gnt_id), 64'(i));
         chk("rr_rdy", 64'(rdy), 64'h1);
      end

      // Move the pointer to 3, then check the wrap from 3 back to 0.
      req = 4'b0100;
      edge_tick();
      req = 4'b1001;
      #1 chk("wrap_gnt_hi", 64'(gnt), 64'h8);
      edge_tick();
      chk("wrap_rdata", 64'(rdata), 64'h13);
      chk("wrap_gnt_lo", 64'(gnt), 64'h1);

      // Stall freezes everything and blanks the grant.
      stall = 1; req = 4'b0010; clr = 1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_gnt", 64'(gnt), 64'h0);
         edge_tick();
         chk("stall_rdata", 64'(rdata), 64'h13);
         chk("stall_rdy", 64'(rdy), 64'h1);
         chk("stall_gnt_id", 64'(gnt_id), 64'h3);
      end

      // Write beats clear on the same edge; a lone clear only drops rdy.
      stall = 0; req = 4'b0100; clr = 1; wdata[2*DW +: DW] = 32'hDEAD;
      edge_tick();
      chk("wrclr_rdata", 64'(rdata), 64'hDEAD);
      chk("wrclr_rdy", 64'(rdy), 64'h1);
      req = '0;
      edge_tick();
      chk("clr_rdy", 64'(rdy), 64'h0);
      chk("clr_rdata", 64'(rdata), 64'hDEAD);
      chk("clr_gnt_id", 64'(gnt_id), 64'h2);
      clr = 0;
      edge_tick();
      chk("idle_rdy", 64'(rdy), 64'h0);

      // Mixed directed vectors, covered by the model.
      req = 4'b0110; edge_tick();
      req = 4'b1010; stall = 1; edge_tick();
      stall = 0; edge_tick();
      req = 4'b0001; clr = 1; edge_tick();
      req = 4'b1101; clr = 0; edge_tick();
      edge_tick();

      // Reset in mid-cycle wipes the register at once; requester 0 wins first after.
      req = 4'b1111;
      edge_tick();
      #2 rst = 1'b0;
      #1 chk("midrst_rdata", 64'(rdata), 64'h0);
      chk("midrst_rdy", 64'(rdy), 64'h0);
      chk("midrst_gnt_id", 64'(gnt_id), 64'h0);
      edge_tick();
      rst = 1'b1;
      edge_tick();
      chk("postrst_gnt_id", 64'(gnt_id), 64'h0);
      chk("postrst_rdata", 64'(rdata), 64'h10);
      chk("postrst_rdy", 64'(rdy), 64'h1);

`ifdef REG_ARB_LOCK_EN
      // Requester 1 takes ownership, keeps it under full contention, then hands on to 2.
      req = 4'b0010; lock = 4'b0010;
      edge_tick();
      req = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         #1 chk("lock_gnt", 64'(gnt), 64'h2);
         edge_tick();
         chk("lock_gnt_id", 64'(gnt_id), 64'h1);
      end
      lock = '0;
      edge_tick();
      chk("unlock_gnt", 64'(gnt), 64'h4);
      edge_tick();
      chk("unlock_gnt_id", 64'(gnt_id), 64'h2);
`endif

      req = '0;
      edge_tick();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
